// File: rtl/fifo_drain_fsm.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_fsm
// Summary  : Drains N+1 entries from a filled FIFO. Each entry is popped,
//            captured, and presented on a valid/ack handshake. A single-cycle
//            done pulse follows acceptance of the last entry.
// Options  : Define FIFO_DRAIN_SUM_EN to add the sum_out accumulator port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_drain_fsm #(
    parameter int DATA_W = 8,
    parameter int N_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_W-1:0]    N,
    input  logic              fifo_ready,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef FIFO_DRAIN_SUM_EN
    ,
    output logic [DATA_W+N_W-1:0] sum_out
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_FULL = 3'd1;
    localparam logic [2:0] S_FETCH     = 3'd2;
    localparam logic [2:0] S_HOLD      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]     state;
    logic [2:0]     next_state;
    logic [N_W-1:0] n_q;
    logic [N_W-1:0] idx;
    logic           at_last;

    // idx is compared before it is incremented, so N = 2^N_W-1 never overflows
    assign at_last = (idx == n_q);

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (start)      next_state = S_WAIT_FULL;
            S_WAIT_FULL: if (fifo_ready) next_state = S_FETCH;
            S_FETCH:                     next_state = S_HOLD;
            S_HOLD: begin
                if (out_ack) begin
                    next_state = at_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE:                      next_state = S_IDLE;
            default:                     next_state = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state only
    always_comb begin
        pop       = (state == S_FETCH);
        out_valid = (state == S_HOLD);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    // Datapath: latch N on accepted start, capture entry in FETCH, step idx on ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q      <= '0;
            idx      <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q <= N;
                        idx <= '0;
                    end
                end
                S_FETCH: begin
                    out_data <= rd_data;
                    out_last <= at_last;
                end
                S_HOLD: begin
                    if (out_ack && !at_last) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_DRAIN_SUM_EN
    // Running unsigned sum of accepted entries; cleared on accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_out <= '0;
        end else if (state == S_IDLE && start) begin
            sum_out <= '0;
        end else if (state == S_HOLD && out_ack) begin
            sum_out <= sum_out + {{N_W{1'b0}}, out_data};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_drain_fsm
// Summary  : Self-checking bench for fifo_drain_fsm. Table rows and random
//            drains are checked against a transaction-level expectation of
//            pops, handshake timing, entry order and done timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  N;
    logic        fifo_ready;
    logic [7:0]  rd_data;
    logic        pop;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ack;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef FIFO_DRAIN_SUM_EN
    logic [11:0] sum_out;
`endif

    always #5 clk = ~clk;

    fifo_drain_fsm #(.DATA_W(8), .N_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .N          (N),
        .fifo_ready (fifo_ready),
        .rd_data    (rd_data),
        .pop        (pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
`ifdef FIFO_DRAIN_SUM_EN
        ,
        .sum_out    (sum_out)
`endif
    );

    // Upstream storage and read pointer: pointer wraps at the drain's N
    logic [7:0] mem [16];
    logic [3:0] rd_ptr;
    int         cur_n;

    assign rd_data = mem[rd_ptr];

    always @(posedge clk or negedge rst) begin
        if (!rst)
            rd_ptr <= 4'd0;
        else if (pop)
            rd_ptr <= (rd_ptr == cur_n[3:0]) ? 4'd0 : rd_ptr + 4'd1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        int n;
        int ready_at;   // negedge index (start at 0) where fifo_ready rises
        int stall;      // ack held low for this many HOLD cycles of entry 0; -1 = random ack
        int pat;        // 0 random, 1 0x11*(i+1), 2 all 0xFF
        int change_n;
        int spam;       // random start pulses while busy
        int abort_at;   // reset during HOLD of this entry; -1 = none
        int exp_pops;
        int exp_first;  // negedge index of first pop
    } vec_t;

    vec_t tbl [10];

    task automatic run_drain(input vec_t v);
        int     exp_pop, exp_done, acc_cnt, pop_cnt, first_pop, stall_left;
        bit     hold_exp, finished;
        longint exp_sum;
        cur_n = v.n;
        exp_sum = 0;
        for (int i = 0; i < 16; i++) begin
            case (v.pat)
                1:       mem[i] = 8'(8'h11 * (i + 1));
                2:       mem[i] = 8'hFF;
                default: mem[i] = 8'($urandom);
            endcase
            if (i <= v.n) exp_sum += mem[i];
        end
        exp_pop    = ((v.ready_at < 1) ? 1 : v.ready_at) + 1;
        exp_done   = -1;
        acc_cnt    = 0;
        pop_cnt    = 0;
        first_pop  = -1;
        stall_left = v.stall;
        hold_exp   = 0;
        finished   = 0;

        @(negedge clk);
        start      = 1'b1;
        N          = v.n[3:0];
        fifo_ready = (v.ready_at <= 0);
        out_ack    = 1'($urandom);

        for (int k = 1; k < 600; k++) begin
            @(negedge clk);
            chk("out_valid", out_valid, hold_exp);
            chk("pop_timing", pop, k == exp_pop);
            chk("done_timing", done, k == exp_done);
            chk("busy_during", busy, 1);
            if (pop) begin
                pop_cnt++;
                if (first_pop < 0) first_pop = k;
            end
`ifdef FIFO_DRAIN_SUM_EN
            if (k == 1) chk("sum_clear", sum_out, 0);
`endif
            if (k == exp_done) begin
`ifdef FIFO_DRAIN_SUM_EN
                chk("sum_done", sum_out, exp_sum[31:0]);
`endif
                start    = 1'b0;
                out_ack  = 1'b0;
                finished = 1;
                break;
            end
            if (out_valid && acc_cnt <= v.n) begin
                chk("out_data", out_data, mem[acc_cnt]);
                chk("out_last", out_last, acc_cnt == v.n);
            end
            if (v.abort_at >= 0 && hold_exp && acc_cnt == v.abort_at) begin
                rst = 1'b0;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_pop", pop, 0);
                chk("rst_last", out_last, 0);
                @(negedge clk);
                chk("rst_idle", busy, 0);
                rst   = 1'b1;
                start = 1'b0;
                return;
            end
            start = v.spam ? 1'($urandom) : 1'b0;
            if (v.change_n) N = 4'($urandom);
            fifo_ready = (k >= v.ready_at) ? ((pop_cnt > 0) ? 1'($urandom) : 1'b1) : 1'b0;
            if (hold_exp) begin
                if (v.stall < 0)
                    out_ack = 1'($urandom);
                else if (acc_cnt == 0 && stall_left > 0) begin
                    out_ack = 1'b0;
                    stall_left--;
                end else
                    out_ack = 1'b1;
            end else begin
                out_ack = 1'($urandom);
            end
            if (hold_exp && out_ack) begin
                acc_cnt++;
                hold_exp = 0;
                if (acc_cnt == v.n + 1) exp_done = k + 1;
                else                    exp_pop  = k + 1;
            end
            if (k == exp_pop) hold_exp = 1;
        end
        chk("timeout", finished, 1);
        chk("pop_count", pop_cnt, v.exp_pops);
        chk("first_pop", first_pop, v.exp_first);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_done", done, 0);
`ifdef FIFO_DRAIN_SUM_EN
        chk("sum_hold", sum_out, exp_sum[31:0]);
`endif
    endtask

    initial begin
        vec_t rv;
        int   r;
        rst = 1'b0; start = 1'b0; N = 4'd0; fifo_ready = 1'b0; out_ack = 1'b0; cur_n = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        //             n  rdy stall pat chg spam abort pops first
        tbl[0] = '{   3,  1,   0,  1,  0,  0,  -1,   4,  2 };
        tbl[1] = '{   3,  6,   0,  0,  0,  0,  -1,   4,  7 };
        tbl[2] = '{   1,  1,   4,  0,  0,  0,  -1,   2,  2 };
        tbl[3] = '{   0,  1,   0,  0,  0,  1,  -1,   1,  2 };
        tbl[4] = '{  15,  1,   0,  0,  0,  0,  -1,  16,  2 };
        tbl[5] = '{   7,  1,  -1,  0,  1,  1,  -1,   8,  2 };
        tbl[6] = '{   5,  1,   0,  0,  0,  0,   2,   0,  0 };
        tbl[7] = '{   5,  1,   0,  0,  0,  0,  -1,   6,  2 };
        tbl[8] = '{   3,  1,   0,  2,  0,  0,  -1,   4,  2 };
        tbl[9] = '{   3,  2,  -1,  2,  0,  1,  -1,   4,  3 };

        @(negedge clk);
        chk("reset_pop", pop, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_last", out_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_data", out_data, 0);
`ifdef FIFO_DRAIN_SUM_EN
        chk("reset_sum", sum_out, 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 10; t++) run_drain(tbl[t]);

        for (int t = 0; t < 20; t++) begin
            r  = int'($urandom_range(0, 3));
            rv = '{ int'($urandom_range(0, 15)), r, -1, 0, 1, 1, -1, 0, 0 };
            rv.exp_pops  = rv.n + 1;
            rv.exp_first = ((r < 1) ? 1 : r) + 1;
            run_drain(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_drain_fsm.md
Name: fifo_drain_fsm

Overview:
- Downstream consumer of the FIFO pointer stage.
- Waits until the write side has filled N+1 entries (`fifo_ready`), then reads them out one at a time.
- For each entry it pulses `pop` to advance the read pointer, captures the storage read data, and presents it on a valid/ack handshake to the next datapath stage (MAC / result logic).
- Signals `done` after entry index N has been accepted.

Parameters:
- DATA_W, 8, width of one FIFO entry.
- N_W, 4, width of N and of the internal index counter (nibble).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to drain one full FIFO.
- N  input  N_W  last index; entry count is N+1; sampled only on accepted start.
- fifo_ready  input  1  from pointer stage; high while write pointer equals N.
- rd_data  input  DATA_W  storage read data at current read pointer (asynchronous read, valid same cycle).
- pop  output  1  one-cycle strobe to pointer stage; advances read pointer.
- out_data  output  DATA_W  captured entry.
- out_valid  output  1  out_data valid, held until acknowledged.
- out_ack  input  1  downstream accepts out_data when out_valid & out_ack.
- out_last  output  1  high with out_valid when the entry is index N.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last entry is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; pop, out_valid, out_last, busy, done = 0; out_data, idx, n_q = 0.
- States: IDLE, WAIT_FULL, FETCH, HOLD, DONE. All outputs are registered or decoded from state only.
- IDLE: start=1 -> n_q<=N, idx<=0, go WAIT_FULL. Other inputs ignored.
- WAIT_FULL: stay until fifo_ready=1, then go FETCH. No timeout.
- FETCH (exactly 1 cycle):
  - pop=1 (combinational from state).
  - out_data<=rd_data, out_last<=(idx==n_q).
  - Next state HOLD; out_valid=1 from the next cycle.
- HOLD:
  - out_valid=1; out_data and out_last stable.
  - out_ack=0 -> stay.
  - out_ack=1 and idx==n_q -> go DONE.
  - out_ack=1 and idx!=n_q -> idx<=idx+1, go FETCH.
- DONE (exactly 1 cycle): done=1, out_valid=0; next state IDLE.
- Throughput: at most one entry per 2 cycles (FETCH+HOLD).
- Latency:
  - start -> first pop is 2 cycles if fifo_ready is already high.
  - Last ack -> done pulse is 1 cycle.
- Pop count: exactly n_q+1 pop pulses per drain, never more. The read pointer returns to 0 by its own wrap at N.
- Boundary conditions:
  - N=0: single FETCH/HOLD, out_last=1 on that entry.
  - N=2^N_W-1: idx reaches max without overflow; the comparison is made before increment.
  - start while busy: ignored, no re-latch of N.
  - Changes on N input mid-drain: ignored (n_q is used).
  - fifo_ready dropping after WAIT_FULL: ignored.
  - out_ack outside HOLD: ignored.
  - start and out_ack asserted together in IDLE: only start acts.
  - Reset mid-drain: immediate return to IDLE. A pop in flight is dropped; the upstream pointer stage shares rst and also clears.

Optional Feature:
- Macro FIFO_DRAIN_SUM_EN.
- When defined, an extra output port is present: sum_out, width DATA_W+N_W.
  - Cleared on accepted start.
  - Accumulates each entry (unsigned) on out_valid&out_ack.
  - Holds its final value from the done cycle until the next accepted start.
  - Reset value 0.
- When not defined: no sum_out port, no accumulator logic.

Test Plan:
- Basic drain: N=3, fifo_ready=1, rd_data follows pointer as 0x11,0x22,0x33,0x44, out_ack=1 always, pulse start -> 4 pop pulses 2 cycles apart; out_data 0x11..0x44; out_last only on 0x44; done 1 cycle after last ack; busy low after done.
- Wait for fill: start with fifo_ready=0 for 5 cycles, then 1 -> no pop during wait; first pop 1 cycle after fifo_ready rises.
- Backpressure: N=1, out_ack held 0 for 4 cycles in first HOLD -> out_valid stays 1, out_data stable, no second pop until ack; total pops = 2.
- Edge values:
  - N=0 -> one pop, out_last=1, done.
  - N=15 -> exactly 16 pops, idx no overflow.
  - Change N input mid-drain -> pop count unchanged.
- Async reset during HOLD of entry 2 (N=5) -> next edge: IDLE, out_valid=0, busy=0; new start drains 6 entries correctly.
- With FIFO_DRAIN_SUM_EN: N=3, entries 0xFF x4 -> sum_out=0x3FC at done; second start clears to 0 before accumulating.
